// File: rtl/reward_sprite_engine.sv
// reward_sprite_engine
// --------------------
// Single-reward sprite layer for the VGA path. A place pulse loads one reward
// (grid position + type 1..3); the engine then renders a SPRITE x SPRITE bitmap
// read from a shared external synchronous ROM, tinted with the type's colour.
// The reward lives LIFE_FRAMES frames, blinks during its last BLINK_FRAMES
// frames and is retired on expiry (expired pulse) or when eaten (clear pulse).
// o_vga_data is meant to be OR-mixed downstream, so 0 means transparent.
//
// Control inputs are single-cycle pulses, no handshake: a pulse is consumed on
// the rising edge where it is high. Priority: effective place > clear > tick.
//
// Ports
//   i_clk            pixel clock
//   i_rst            synchronous, active-high reset
//   i_place          pulse: load a new reward (ignored when i_reward_type==0)
//   i_clear          pulse: reward eaten, remove it
//   i_frame_tick     pulse once per frame, outside active video
//   i_random_xpos/ypos  grid cell sampled on place
//   i_reward_type    1..3 sampled on place
//   i_vga_xpos/ypos  current pixel (stage 0)
//   o_rom_addr       (type-1)*SPRITE^2 + offset, registered at stage 1
//   i_rom_data       ROM bit, valid ROM_LAT cycles after o_rom_addr
//   o_vga_data       RGB444 pixel, ROM_LAT+2 cycles after its coordinates
//   o_active         reward present (SHOW or BLINK)
//   o_expired        one-cycle pulse when the lifetime runs out
//   o_state          debug view of the FSM state (0 IDLE, 1 SHOW, 2 BLINK)
module reward_sprite_engine #(
  parameter int          CELL         = 20,
  parameter int          ORIGIN_X     = 80,
  parameter int          ORIGIN_Y     = 80,
  parameter int          SPRITE       = 24,
  parameter int          ROM_LAT      = 1,
  parameter int          LIFE_FRAMES  = 600,
  parameter int          BLINK_FRAMES = 120,
  parameter int          BLINK_HALF   = 8,
  parameter logic [11:0] COLOR1       = 12'hFF0,
  parameter logic [11:0] COLOR2       = 12'h0F0,
  parameter logic [11:0] COLOR3       = 12'h0FF,
  localparam int         ADDR_W       = $clog2(3 * SPRITE * SPRITE)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_place,
  input  logic              i_clear,
  input  logic              i_frame_tick,
  input  logic [5:0]        i_random_xpos,
  input  logic [5:0]        i_random_ypos,
  input  logic [1:0]        i_reward_type,
  input  logic [10:0]       i_vga_xpos,
  input  logic [10:0]       i_vga_ypos,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic              i_rom_data,
  output logic [11:0]       o_vga_data,
  output logic              o_active,
  output logic              o_expired,
  output logic [1:0]        o_state
);

  localparam int LIFE_W = $clog2(LIFE_FRAMES + 1);
  localparam int BH_W   = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLINK = 2'd2
  } state_t;

  state_t            r_state;
  logic [LIFE_W-1:0] r_life;
  logic [BH_W-1:0]   r_blink_cnt;
  logic              r_phase;
  logic [1:0]        r_type;
  logic [5:0]        r_x;
  logic [5:0]        r_y;
  logic              r_active;
  logic              r_expired;

  logic [LIFE_W-1:0] w_life_dec;

  assign w_life_dec = r_life - LIFE_W'(1);

  // ---------------------------------------------------------------------------
  // Lifetime FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_life      <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_type      <= 2'd0;
      r_x         <= 6'd0;
      r_y         <= 6'd0;
      r_active    <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (i_place && (i_reward_type != 2'd0)) begin
        // Works from any state, so a place with a clear replaces the reward
        // and a coincident frame tick is dropped.
        r_state     <= ST_SHOW;
        r_x         <= i_random_xpos;
        r_y         <= i_random_ypos;
        r_type      <= i_reward_type;
        r_life      <= LIFE_W'(LIFE_FRAMES);
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
        r_active    <= 1'b1;
      end else if (i_clear && (r_state != ST_IDLE)) begin
        r_state  <= ST_IDLE;
        r_active <= 1'b0;
      end else if (i_frame_tick && (r_state != ST_IDLE)) begin
        r_life <= w_life_dec;
        if (w_life_dec == '0) begin
          r_state   <= ST_IDLE;
          r_active  <= 1'b0;
          r_expired <= 1'b1;
        end else if (r_state == ST_SHOW) begin
          if (w_life_dec == LIFE_W'(BLINK_FRAMES)) begin
            r_state     <= ST_BLINK;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
          end
        end else begin
          // BLINK: the phase flips after every BLINK_HALF ticks spent here.
          if (r_blink_cnt == BH_W'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
          end else begin
            r_blink_cnt <= r_blink_cnt + BH_W'(1);
          end
        end
      end
    end
  end

  assign o_active  = r_active;
  assign o_expired = r_expired;
  assign o_state   = r_state;

  // ---------------------------------------------------------------------------
  // Stage 0: geometry, hit test, ROM offset, visibility and tint
  // ---------------------------------------------------------------------------
  logic [11:0]       w_cx;
  logic [11:0]       w_cy;
  logic [11:0]       w_left;
  logic [11:0]       w_top;
  logic [11:0]       w_vx;
  logic [11:0]       w_vy;
  logic [11:0]       w_dx;
  logic [11:0]       w_dy;
  logic              w_hit;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr;
  logic              w_visible;
  logic [11:0]       w_color;

  assign w_cx   = {6'd0, r_x} * 12'(CELL) + 12'(ORIGIN_X);
  assign w_cy   = {6'd0, r_y} * 12'(CELL) + 12'(ORIGIN_Y);
  assign w_left = w_cx - 12'(SPRITE / 2);
  assign w_top  = w_cy - 12'(SPRITE / 2);
  assign w_vx   = {1'b0, i_vga_xpos};
  assign w_vy   = {1'b0, i_vga_ypos};
  assign w_dx   = w_vx - w_left;
  assign w_dy   = w_vy - w_top;

  assign w_hit = (w_vx >= w_left) && (w_vx < w_left + 12'(SPRITE)) &&
                 (w_vy >= w_top)  && (w_vy < w_top  + 12'(SPRITE));

  // dx/dy are below SPRITE whenever the address is actually used (on a hit).
  assign w_offset = ADDR_W'(w_dy) * ADDR_W'(SPRITE) + ADDR_W'(w_dx);
  assign w_base   = ADDR_W'(r_type - 2'd1) * ADDR_W'(SPRITE * SPRITE);
  assign w_addr   = w_base + w_offset;

  assign w_visible = w_hit && ((r_state == ST_SHOW) ||
                               ((r_state == ST_BLINK) && !r_phase));

  always_comb begin
    w_color = 12'h000;
    case (r_type)
      2'd1:    w_color = COLOR1;
      2'd2:    w_color = COLOR2;
      2'd3:    w_color = COLOR3;
      default: w_color = 12'h000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1 .. ROM_LAT+2: ROM address, visibility/tint delay line, output
  // ---------------------------------------------------------------------------
  // Entry [ROM_LAT] lines up with i_rom_data for the same pixel.
  logic [ROM_LAT:0] r_vis_d;
  logic [11:0]      r_col_d [0:ROM_LAT];
  logic [11:0]      r_vga_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rom_addr <= '0;
      r_vis_d    <= '0;
      r_vga_data <= 12'h000;
      for (int i = 0; i <= ROM_LAT; i++) begin
        r_col_d[i] <= 12'h000;
      end
    end else begin
      // Off-sprite pixels leave the address alone to avoid needless ROM toggles.
      if (w_hit) begin
        o_rom_addr <= w_addr;
      end
      r_vis_d[0] <= w_visible;
      r_col_d[0] <= w_color;
      for (int i = 1; i <= ROM_LAT; i++) begin
        r_vis_d[i] <= r_vis_d[i-1];
        r_col_d[i] <= r_col_d[i-1];
      end
      r_vga_data <= (r_vis_d[ROM_LAT] && i_rom_data) ? r_col_d[ROM_LAT] : 12'h000;
    end
  end

  assign o_vga_data = r_vga_data;

endmodule

// File: tb/tb_reward_sprite_engine.sv
module tb_reward_sprite_engine;

  localparam int LIFE   = 20;
  localparam int BLINKF = 8;
  localparam int BHALF  = 2;
  localparam int LAT    = 3;  // ROM_LAT + 2

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_BLINK = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        place;
  logic        clear;
  logic        tick;
  logic [5:0]  xpos;
  logic [5:0]  ypos;
  logic [1:0]  rtype;
  logic [10:0] vga_x;
  logic [10:0] vga_y;
  logic [10:0] rom_addr;
  logic        rom_q;
  logic [11:0] vga_data;
  logic        active;
  logic        expired;
  logic [1:0]  state;

  always #5 clk = ~clk;

  reward_sprite_engine #(
    .LIFE_FRAMES (LIFE),
    .BLINK_FRAMES(BLINKF),
    .BLINK_HALF  (BHALF)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_place      (place),
    .i_clear      (clear),
    .i_frame_tick (tick),
    .i_random_xpos(xpos),
    .i_random_ypos(ypos),
    .i_reward_type(rtype),
    .i_vga_xpos   (vga_x),
    .i_vga_ypos   (vga_y),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_q),
    .o_vga_data   (vga_data),
    .o_active     (active),
    .o_expired    (expired),
    .o_state      (state)
  );

  // ---------------------------------------------------------------------------
  // ROM model: one-cycle synchronous read, mode 0 = all ones, 1 = checkerboard
  // ---------------------------------------------------------------------------
  int rom_mode = 0;

  function automatic logic rom_bit(input logic [10:0] a, input int mode);
    int off;
    off = int'(a) % 576;
    if (mode == 0) return 1'b1;
    return (((off / 24) + (off % 24)) % 2) == 0;
  endfunction

  always @(posedge clk) rom_q <= rom_bit(rom_addr, rom_mode);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int exp_pulses = 0;

  logic [11:0] exp_q[$];
  int          due_q[$];
  logic [11:0] sb_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (expired === 1'b1) exp_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      sb_exp = exp_q.pop_front();
      void'(due_q.pop_front());
      check("pixel", {20'd0, vga_data}, {20'd0, sb_exp});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push_px(input int vx, input int vy, input bit chk, input logic [11:0] exp);
    vga_x = 11'(vx);
    vga_y = 11'(vy);
    if (chk) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + LAT);
    end
  endtask

  task automatic drive_px(input int vx, input int vy, input bit chk, input logic [11:0] exp);
    @(negedge clk);
    push_px(vx, vy, chk, exp);
  endtask

  task automatic ctrl(input logic pl, input logic cl, input logic ft,
                      input int x, input int y, input int t);
    @(negedge clk);
    place = pl;
    clear = cl;
    tick  = ft;
    xpos  = 6'(x);
    ypos  = 6'(y);
    rtype = 2'(t);
    @(negedge clk);
    place = 1'b0;
    clear = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) ctrl(1'b0, 1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic flush();
    int n;
    n = 0;
    while (due_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("flush_pending", due_q.size(), 0);
    exp_q.delete();
    due_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          x;
    int          y;
    int          t;
    int          mode;
    int          vx;
    int          vy;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int e0;
    bit vis;
    bit seen;
    logic [1:0] exp_state;

    vecs[0]  = '{3, 2, 2, 0, 128, 108, 12'h0F0};
    vecs[1]  = '{3, 2, 2, 0, 127, 108, 12'h000};
    vecs[2]  = '{3, 2, 2, 0, 152, 108, 12'h000};
    vecs[3]  = '{3, 2, 2, 0, 151, 131, 12'h0F0};
    vecs[4]  = '{3, 2, 2, 0, 151, 132, 12'h000};
    vecs[5]  = '{3, 2, 2, 0, 128, 107, 12'h000};
    vecs[6]  = '{0, 0, 1, 0, 68, 68, 12'hFF0};
    vecs[7]  = '{0, 0, 1, 0, 91, 91, 12'hFF0};
    vecs[8]  = '{0, 0, 1, 0, 92, 91, 12'h000};
    vecs[9]  = '{5, 1, 3, 1, 168, 88, 12'h0FF};
    vecs[10] = '{5, 1, 3, 1, 169, 88, 12'h000};
    vecs[11] = '{5, 1, 3, 1, 169, 89, 12'h0FF};
    vecs[12] = '{63, 63, 1, 0, 1328, 1328, 12'hFF0};
    vecs[13] = '{63, 63, 3, 0, 1351, 1351, 12'h0FF};

    rst   = 1'b1;
    place = 1'b0;
    clear = 1'b0;
    tick  = 1'b0;
    xpos  = 6'd0;
    ypos  = 6'd0;
    rtype = 2'd0;
    vga_x = 11'd128;
    vga_y = 11'd108;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vga_data", {20'd0, vga_data}, 32'h0);
    check("rst_rom_addr", {21'd0, rom_addr}, 32'h0);
    check("rst_active", {31'd0, active}, 32'h0);
    check("rst_expired", {31'd0, expired}, 32'h0);
    check("rst_state", {30'd0, state}, {30'd0, S_IDLE});
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive_px(128, 108, 1'b1, 12'h000);
    flush();

    // Table-driven single-pixel probes
    for (int i = 0; i < 14; i++) begin
      rom_mode = vecs[i].mode;
      ctrl(1'b1, 1'b0, 1'b0, vecs[i].x, vecs[i].y, vecs[i].t);
      drive_px(vecs[i].vx, vecs[i].vy, 1'b1, vecs[i].exp);
      flush();
    end

    // ROM address for the top-left pixel of a type-2 reward
    rom_mode = 0;
    ctrl(1'b1, 1'b0, 1'b0, 3, 2, 2);
    drive_px(128, 108, 1'b1, 12'h0F0);
    @(negedge clk);
    check("rom_addr_type2", {21'd0, rom_addr}, 32'd576);
    flush();

    // Checkerboard row scan in the type-3 bank (row 1 of the sprite)
    rom_mode = 1;
    ctrl(1'b1, 1'b0, 1'b0, 5, 1, 3);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c > 0) check("rom_addr_row", {21'd0, rom_addr}, 32'(1152 + 24 + c - 1));
      push_px(168 + c, 89, 1'b1, (((1 + c) % 2) == 0) ? 12'h0FF : 12'h000);
    end
    @(negedge clk);
    check("rom_addr_row_end", {21'd0, rom_addr}, 32'(1152 + 24 + 23));
    flush();

    // Lifetime and blink
    rom_mode = 0;
    ctrl(1'b1, 1'b0, 1'b0, 3, 2, 2);
    check("life_state0", {30'd0, state}, {30'd0, S_SHOW});
    check("life_active0", {31'd0, active}, 32'h1);
    e0 = exp_pulses;
    for (int k = 1; k <= LIFE; k++) begin
      ticks(1);
      exp_state = (k < LIFE - BLINKF) ? S_SHOW : (k < LIFE) ? S_BLINK : S_IDLE;
      vis = (k < LIFE) && !((k >= LIFE - BLINKF) && ((((k - (LIFE - BLINKF)) / BHALF) % 2) == 1));
      check($sformatf("life_state_t%0d", k), {30'd0, state}, {30'd0, exp_state});
      check($sformatf("life_active_t%0d", k), {31'd0, active}, {31'd0, k < LIFE});
      check($sformatf("life_expired_t%0d", k), {31'd0, expired}, {31'd0, k == LIFE});
      drive_px(128, 108, 1'b1, vis ? 12'h0F0 : 12'h000);
      flush();
    end
    check("expired_pulse_count", exp_pulses - e0, 32'd1);
    check("active_after_expiry", {31'd0, active}, 32'h0);

    // Eaten mid-SHOW
    ctrl(1'b1, 1'b0, 1'b0, 3, 2, 2);
    drive_px(128, 108, 1'b1, 12'h0F0);
    flush();
    ctrl(1'b0, 1'b1, 1'b0, 0, 0, 0);
    check("clear_state", {30'd0, state}, {30'd0, S_IDLE});
    check("clear_active", {31'd0, active}, 32'h0);
    drive_px(128, 108, 1'b1, 12'h000);
    flush();

    // Type-0 place in IDLE is ignored
    ctrl(1'b1, 1'b0, 1'b0, 3, 2, 0);
    check("type0_active", {31'd0, active}, 32'h0);
    check("type0_state", {30'd0, state}, {30'd0, S_IDLE});
    drive_px(128, 108, 1'b1, 12'h000);
    flush();

    // place + clear together replaces the reward with a fresh lifetime
    ctrl(1'b1, 1'b0, 1'b0, 3, 2, 2);
    ticks(5);
    ctrl(1'b1, 1'b1, 1'b0, 5, 1, 2);
    check("replace_state", {30'd0, state}, {30'd0, S_SHOW});
    check("replace_active", {31'd0, active}, 32'h1);
    drive_px(128, 108, 1'b1, 12'h000);
    drive_px(168, 88, 1'b1, 12'h0F0);
    flush();
    ticks(LIFE - BLINKF - 1);
    check("replace_life_show", {30'd0, state}, {30'd0, S_SHOW});
    ticks(1);
    check("replace_life_blink", {30'd0, state}, {30'd0, S_BLINK});

    // frame_tick coincident with place is dropped
    ctrl(1'b1, 1'b0, 1'b0, 3, 2, 2);
    ticks(3);
    ctrl(1'b1, 1'b0, 1'b1, 3, 2, 2);
    ticks(LIFE - BLINKF - 1);
    check("tick_place_show", {30'd0, state}, {30'd0, S_SHOW});
    ticks(1);
    check("tick_place_blink", {30'd0, state}, {30'd0, S_BLINK});

    // Type-0 place while up changes nothing (still BLINK phase 0, visible)
    ctrl(1'b1, 1'b0, 1'b0, 5, 1, 0);
    check("type0_show_state", {30'd0, state}, {30'd0, S_BLINK});
    drive_px(128, 108, 1'b1, 12'h0F0);
    drive_px(168, 88, 1'b1, 12'h000);
    flush();

    // Reset during active video while blinking
    e0 = exp_pulses;
    drive_px(128, 108, 1'b0, 12'h000);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (vga_data === 12'h0F0) seen = 1'b1;
    end
    check("pre_reset_visible", {31'd0, seen}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_vga_data", {20'd0, vga_data}, 32'h0);
    check("midrst_active", {31'd0, active}, 32'h0);
    check("midrst_state", {30'd0, state}, {30'd0, S_IDLE});
    check("midrst_expired", {31'd0, expired}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_vga_data", {20'd0, vga_data}, 32'h0);
    end
    check("midrst_no_expire", exp_pulses - e0, 32'd0);

    flush();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1);
  end

endmodule
